// File: rtl/gray_pkg.sv
// gray_pkg: shared helpers for the Gray-code counter family.
//   bin2gray  - binary to reflected Gray code
//   gray2bin  - Gray code to binary, prefix XOR running down from the MSB
//   all_ones  - word with the low 'width' bits set (counter maximum)
// The helpers work on a fixed 64-bit word so that any counter up to 64 bits
// wide can use them: callers zero-extend their value on the way in and
// truncate the result on the way out.
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended inputs leave the upper bits at zero, so starting the
    // prefix XOR at bit 63 gives the right answer for any narrower width.
    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin = {GRAY_MAX_W{1'b0}};
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic gray_word_t all_ones(input int width);
        gray_word_t r;
        r = {GRAY_MAX_W{1'b0}};
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            if (i < width) begin
                r[i] = 1'b1;
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin: purely combinational Gray-to-binary converter.
// Used on the load path of gray_counter_bus and usable by any receiver of
// the Gray-coded bus that needs the binary count back.
// Ports:
//   gray  in  [WIDTH-1:0]  Gray-coded value
//   bin   out [WIDTH-1:0]  equivalent binary value
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(gray2bin(gray_word_t'(gray)));

endmodule

// File: rtl/gray_counter_bus.sv
// gray_counter_bus: parametrised Gray-code up/down counter with a tri-state
// bus driver.
//   - Counts up or down when en=1, loads a Gray value when load=1,
//     wraps or saturates at the limits (SATURATE), and flags wrap / at_max /
//     at_min with registered outputs.
//   - Priority on each rising edge: reset > load > en > hold.
//   - The registered Gray value drives 'data' (optionally inverted) whenever
//     write_enable is high; the bus floats otherwise. The bus path is
//     combinational so enable/disable takes effect in the same cycle.
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   en            in   count enable
//   up            in   1 = increment, 0 = decrement
//   load          in   synchronous load strobe
//   load_gray     in   [WIDTH-1:0] Gray value to load
//   write_enable  in   bus drive enable
//   data          out  [WIDTH-1:0] tri-state bus
//   gray_q        out  [WIDTH-1:0] registered Gray value
//   wrap          out  one-cycle pulse on wrap or blocked step
//   at_max        out  count is all ones
//   at_min        out  count is zero
// WIDTH must be at least 2.
module gray_counter_bus
    import gray_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int INVERT_OUT = 1,
    parameter int SATURATE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    input  logic             write_enable,
    output wire  [WIDTH-1:0] data,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(all_ones(WIDTH));
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] gray_q_r;
    logic             wrap_r;
    logic             at_max_r;
    logic             at_min_r;

    logic [WIDTH-1:0] load_bin_s;
    logic [WIDTH-1:0] b_next_s;
    logic             wrap_next_s;
    logic [WIDTH-1:0] gray_next_s;
    logic [WIDTH-1:0] bus_val_s;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_load_conv (
        .gray (load_gray),
        .bin  (load_bin_s)
    );

    // Next binary count and wrap flag: load > count > hold.
    always_comb begin
        b_next_s    = b_r;
        wrap_next_s = 1'b0;
        if (load) begin
            b_next_s = load_bin_s;
        end else if (en) begin
            if (up) begin
                if (b_r == MAX_C) begin
                    wrap_next_s = 1'b1;
                    if (SATURATE != 0) begin
                        b_next_s = b_r;
                    end else begin
                        b_next_s = ZERO_C;
                    end
                end else begin
                    b_next_s = b_r + ONE_C;
                end
            end else begin
                if (b_r == ZERO_C) begin
                    wrap_next_s = 1'b1;
                    if (SATURATE != 0) begin
                        b_next_s = b_r;
                    end else begin
                        b_next_s = MAX_C;
                    end
                end else begin
                    b_next_s = b_r - ONE_C;
                end
            end
        end else begin
            b_next_s = b_r;
        end
    end

    // Gray value is registered from the next binary count, never decoded
    // from the current one, so gray_q is glitch-free and aligned with b_r.
    assign gray_next_s = WIDTH'(bin2gray(gray_word_t'(b_next_s)));

    // State and status registers; reset overrides load and en.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_r      <= ZERO_C;
            gray_q_r <= ZERO_C;
            wrap_r   <= 1'b0;
            at_max_r <= 1'b0;
            at_min_r <= 1'b1;
        end else begin
            b_r      <= b_next_s;
            gray_q_r <= gray_next_s;
            wrap_r   <= wrap_next_s;
            at_max_r <= (b_next_s == MAX_C);
            at_min_r <= (b_next_s == ZERO_C);
        end
    end

    assign bus_val_s = (INVERT_OUT != 0) ? ~gray_q_r : gray_q_r;
    assign data      = write_enable ? bus_val_s : {WIDTH{1'bz}};

    assign gray_q = gray_q_r;
    assign wrap   = wrap_r;
    assign at_max = at_max_r;
    assign at_min = at_min_r;

endmodule
